// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared defaults for the UART receive-side buffer.
//   DEFAULT_DATA_WIDTH : word width matching the receiver P_DATA
//   DEFAULT_DEPTH      : buffer entries (power of two, >= 2)
//   DEFAULT_ADDR_BITS  : log2(DEFAULT_DEPTH)
//   DEFAULT_PTR_WIDTH  : pointer width including the wrap bit
package uart_rx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_ADDR_BITS  = $clog2(DEFAULT_DEPTH);
    localparam int unsigned DEFAULT_PTR_WIDTH  = DEFAULT_ADDR_BITS + 1;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// fifo_mem: dual-port storage for uart_rx_fifo.
// Synchronous write port, asynchronous (combinational) read port.
// Ports:
//   clk      : write clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_addr  : read address
//   rd_data  : word stored at rd_addr
// The array is deliberately not reset.
module fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FWFT buffer downstream of the UART receiver.
// Ports:
//   CLK, RST     : clock (rising edge), asynchronous active-high reset
//   P_DATA       : received word, captured when DATA_VALID pulses
//   DATA_VALID   : one-cycle push strobe
//   RD_DATA      : head-of-buffer word (valid while RD_VALID)
//   RD_VALID     : buffer non-empty
//   RD_READY     : host accepts RD_DATA this cycle
//   FIFO_LEVEL   : registered entry count, 0..DEPTH
//   OVERFLOW     : sticky flag, a word was dropped while full
//   OVF_CLR      : synchronous clear of OVERFLOW (a same-cycle overflow wins)
//   ALMOST_FULL  : registered (next level >= AF_THRESH); only when
//                  UART_RX_FIFO_AF_EN is defined
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter int unsigned AF_THRESH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [ADDR_BITS:0]    FIFO_LEVEL,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
`ifdef UART_RX_FIFO_AF_EN
    ,
    output logic                  ALMOST_FULL
`endif
);

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2 || DEPTH != (1 << ADDR_BITS)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_BITS");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_rx_fifo: AF_THRESH must be in 1..DEPTH");
    end

    logic [ADDR_BITS:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0] wr_ptr_next, rd_ptr_next;
    logic [ADDR_BITS:0] level_next;
    logic               empty, full;
    logic               push, pop, ovf_event;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
                   (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);

    assign pop       = !empty && RD_READY;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push      = DATA_VALID && (!full || pop);
    assign ovf_event = DATA_VALID && full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (push) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        level_next = wr_ptr_next - rd_ptr_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            FIFO_LEVEL <= level_next;
            if (ovf_event) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    localparam logic [ADDR_BITS:0] AF_LEVEL = AF_THRESH[ADDR_BITS:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALMOST_FULL <= 1'b0;
        end else begin
            ALMOST_FULL <= (level_next >= AF_LEVEL);
        end
    end
`endif

    assign RD_VALID = !empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_BITS-1:0]),
        .wr_data (P_DATA),
        .rd_addr (rd_ptr[ADDR_BITS-1:0]),
        .rd_data (RD_DATA)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ALMOST_FULL checks are active when UART_RX_FIFO_AF_EN is defined.
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       RD_READY;
    logic [3:0] FIFO_LEVEL;
    logic       OVERFLOW;
    logic       OVF_CLR;
`ifdef UART_RX_FIFO_AF_EN
    logic       ALMOST_FULL;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 CLK = ~CLK;

    uart_rx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .ADDR_BITS  (3),
        .AF_THRESH  (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .RD_READY    (RD_READY),
        .FIFO_LEVEL  (FIFO_LEVEL),
        .OVERFLOW    (OVERFLOW),
        .OVF_CLR     (OVF_CLR)
`ifdef UART_RX_FIFO_AF_EN
        ,
        .ALMOST_FULL (ALMOST_FULL)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        P_DATA     = d;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
    endtask

    task automatic pop();
        RD_READY = 1'b1;
        step();
        RD_READY = 1'b0;
    endtask

    task automatic check_af(input string tag, input logic exp);
`ifdef UART_RX_FIFO_AF_EN
        check(tag, {31'd0, ALMOST_FULL}, {31'd0, exp});
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_seq [8];

        RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; RD_READY = 1'b0; OVF_CLR = 1'b0;
        step(); step();
        RST = 1'b0;
        step();

        // Reset state
        check("rst_valid", {31'd0, RD_VALID}, 32'd0);
        check("rst_level", {28'd0, FIFO_LEVEL}, 32'd0);
        check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
        check_af("rst_af", 1'b0);

        // Single word, first-word fall-through
        push(8'hA5);
        check("a5_valid", {31'd0, RD_VALID}, 32'd1);
        check("a5_data", {24'd0, RD_DATA}, 32'hA5);
        check("a5_level", {28'd0, FIFO_LEVEL}, 32'd1);
        pop();
        check("a5_pop_valid", {31'd0, RD_VALID}, 32'd0);
        check("a5_pop_level", {28'd0, FIFO_LEVEL}, 32'd0);

        // Fill with 0x01..0x08, no reads
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            check($sformatf("fill_level_%0d", i), {28'd0, FIFO_LEVEL}, i);
            check_af($sformatf("fill_af_%0d", i), i >= 6);
        end
        check("fill_ovf", {31'd0, OVERFLOW}, 32'd0);

        // 9th push is dropped
        push(8'h09);
        check("ovf_set", {31'd0, OVERFLOW}, 32'd1);
        check("ovf_level", {28'd0, FIFO_LEVEL}, 32'd8);
        check("ovf_head", {24'd0, RD_DATA}, 32'h01);

        OVF_CLR = 1'b1;
        step();
        OVF_CLR = 1'b0;
        check("ovf_clr", {31'd0, OVERFLOW}, 32'd0);

        // Full buffer, simultaneous push and pop
        P_DATA = 8'h55; DATA_VALID = 1'b1; RD_READY = 1'b1;
        step();
        DATA_VALID = 1'b0; RD_READY = 1'b0;
        check("pp_level", {28'd0, FIFO_LEVEL}, 32'd8);
        check("pp_ovf", {31'd0, OVERFLOW}, 32'd0);
        check("pp_head", {24'd0, RD_DATA}, 32'h02);

        // Drain: 0x02..0x08 then 0x55
        for (int i = 0; i < 7; i++) exp_seq[i] = 8'(i + 2);
        exp_seq[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'd0, RD_VALID}, 32'd1);
            check($sformatf("drain_data_%0d", i), {24'd0, RD_DATA}, {24'd0, exp_seq[i]});
            pop();
            check($sformatf("drain_level_%0d", i), {28'd0, FIFO_LEVEL}, 7 - i);
            check_af($sformatf("drain_af_%0d", i), (7 - i) >= 6);
        end
        check("drain_empty", {31'd0, RD_VALID}, 32'd0);

        // Streaming with RD_READY high across pointer wrap
        RD_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            P_DATA = 8'(8'h30 + i); DATA_VALID = 1'b1;
            step();
            check($sformatf("stream_data_%0d", i), {24'd0, RD_DATA}, 32'h30 + i);
            check($sformatf("stream_level_%0d", i), {28'd0, FIFO_LEVEL}, 32'd1);
        end
        DATA_VALID = 1'b0;
        step();
        RD_READY = 1'b0;
        check("stream_end_level", {28'd0, FIFO_LEVEL}, 32'd0);
        check("stream_end_valid", {31'd0, RD_VALID}, 32'd0);

        // Overflow coinciding with OVF_CLR: set wins
        for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
        check("refill_level", {28'd0, FIFO_LEVEL}, 32'd8);
        P_DATA = 8'hEE; DATA_VALID = 1'b1; OVF_CLR = 1'b1;
        step();
        DATA_VALID = 1'b0;
        check("ovf_vs_clr", {31'd0, OVERFLOW}, 32'd1);
        step();
        OVF_CLR = 1'b0;
        check("ovf_clr_alone", {31'd0, OVERFLOW}, 32'd0);
        check("refill_head", {24'd0, RD_DATA}, 32'hC0);

        // Asynchronous reset with level 5
        pop(); pop(); pop();
        check("pre_rst_level", {28'd0, FIFO_LEVEL}, 32'd5);
        check("pre_rst_head", {24'd0, RD_DATA}, 32'hC3);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_level", {28'd0, FIFO_LEVEL}, 32'd0);
        check("async_rst_valid", {31'd0, RD_VALID}, 32'd0);
        step();
        RST = 1'b0;
        step();
        check("post_rst_level", {28'd0, FIFO_LEVEL}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver top level. Captures every `P_DATA` word qualified by the receiver's single-cycle `DATA_VALID` pulse into a circular buffer and presents it to the host through a first-word-fall-through valid/ready read port. Decouples host read latency from line rate, reports fill level, and flags lost frames with a sticky overflow bit.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; matches receiver `P_DATA`.
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `ADDR_BITS`, 3: log2(`DEPTH`).
- `AF_THRESH`, 6: almost-full threshold; used only with the macro; range 1..`DEPTH`.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `P_DATA`  in  `DATA_WIDTH`: received word from the UART receiver.
- `DATA_VALID`  in  1: one-cycle push strobe from the receiver.
- `RD_DATA`  out  `DATA_WIDTH`: head-of-buffer word.
- `RD_VALID`  out  1: buffer non-empty; `RD_DATA` is valid.
- `RD_READY`  in  1: host accepts `RD_DATA` this cycle.
- `FIFO_LEVEL`  out  `ADDR_BITS+1`: current entry count, 0..`DEPTH`.
- `OVERFLOW`  out  1: sticky; at least one word dropped.
- `OVF_CLR`  in  1: synchronous clear of `OVERFLOW`.
- `ALMOST_FULL`  out  1: present only with `UART_RX_FIFO_AF_EN`.

## Operation
- Storage: `DEPTH` x `DATA_WIDTH` array. Write pointer and read pointer are each `ADDR_BITS+1` wide; the MSB is the wrap bit.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Push occurs when `DATA_VALID` is high and either the buffer is not full, or a pop occurs in the same cycle.
- Pop occurs when `RD_VALID` and `RD_READY` are both high.
- Pointers increment modulo 2^(`ADDR_BITS+1`). Wrap is natural binary rollover; no special-casing.
- `RD_DATA` is a combinational read of `mem[rd_ptr[ADDR_BITS-1:0]]`. `RD_VALID` is `!empty`.
- `FIFO_LEVEL` equals `wr_ptr - rd_ptr`, computed in `ADDR_BITS+1` bits and registered in lockstep with the pointers. Changes per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Overflow: `DATA_VALID` while full with no pop in the same cycle.
  - The word is discarded; memory and pointers are untouched.
  - `OVERFLOW` is set on the next edge.
- `OVF_CLR` clears `OVERFLOW`. If an overflow event coincides with `OVF_CLR`, set wins.
- Empty buffer with `DATA_VALID` and `RD_READY` both high: push only. No pop occurs, because `RD_VALID` is low.
- Reset mid-operation discards all contents; any push in flight is lost.
- Host must hold `RD_DATA` sampling to cycles where `RD_VALID` is high. `RD_DATA` is don't-care while empty.

## Timing
- Reset values:
  - `RD_VALID`=0, `FIFO_LEVEL`=0, `OVERFLOW`=0, `ALMOST_FULL`=0.
  - Pointers are 0. Memory is not reset. `RD_DATA` is don't-care.
- Write-to-read latency: a push on edge N makes `RD_VALID` high immediately after edge N. The host can pop at edge N+1.
- Pop updates take effect after the popping edge: the next word, or `RD_VALID`=0, appears in the same cycle after that edge.
- Full throughput: one push and one pop per cycle, sustained.
- `DATA_VALID` pulses are at least one bit-time apart; back-to-back pushes are still supported.

## Configuration
- Macro `UART_RX_FIFO_AF_EN`.
- When defined:
  - `ALMOST_FULL` port exists.
  - It is a register equal to (next `FIFO_LEVEL` >= `AF_THRESH`), so it updates on the same edge as `FIFO_LEVEL`.
  - It resets to 0.
- When undefined: the port and its logic are absent, and `AF_THRESH` is ignored.

## Structure
- Shared package or header `uart_rx_pkg` holds:
  - Default `DATA_WIDTH` and `DEPTH`.
  - Derived `ADDR_BITS` width constant.
  - Pointer width `ADDR_BITS+1`.
- One sub-module, `fifo_mem`: dual-port storage with a synchronous write port and an asynchronous read port.
- Pointer, flag, and level logic stay in `uart_rx_fifo`.

## Test plan
- Reset then idle: all outputs are at their reset values. Push 0xA5 -> next cycle `RD_VALID`=1, `RD_DATA`=0xA5, `FIFO_LEVEL`=1.
- Push 0x01..0x08 with `RD_READY`=0:
  - `FIFO_LEVEL`=8, full.
  - 9th push of 0x09 -> `OVERFLOW`=1, level stays 8.
  - Drain yields 0x01..0x08 in order.
- Full buffer with `DATA_VALID` (0x55) and `RD_READY` high together: 0x01 popped, 0x55 stored, level stays 8, `OVERFLOW` stays 0.
- 20 words through with `RD_READY` tied high (pointer wrap): output sequence equals input, and level never exceeds 1.
- Overflow event coinciding with `OVF_CLR` -> `OVERFLOW`=1. A later `OVF_CLR` alone -> 0.
- With `UART_RX_FIFO_AF_EN` and `AF_THRESH`=6:
  - `ALMOST_FULL` rises on the edge of the 6th push.
  - It falls on the edge where the level drops to 5.
- Assert `RST` with level 5 -> level=0 and `RD_VALID`=0 immediately.
